seq_detect_param: RTL and testbench
===================================

# seq_detect_param

Parametrised serial bit-pattern detector, the successor to the fixed 4-bit sequence detectors in the FSM collection. It supports a runtime-programmable pattern of 1..MAX_LEN bits, a selectable overlapping or non-overlapping mode, input qualification via `din_valid`, and a saturating match counter. Reset defaults reproduce the classic overlapping "1011" detector, so existing benches work unchanged.

## Interface
- `MAX_LEN`, 8: maximum pattern length in bits, ≥2.
- `CNT_W`, 8: width of the match counter.
- `RST_PAT`, 8'b0000_1011: pattern loaded at reset, MAX_LEN bits wide.
- `RST_LEN`, 4: pattern length loaded at reset.
- `RST_OVL`, 1: overlap mode loaded at reset.
- `LEN_W`, $clog2(MAX_LEN+1): derived width of the length fields.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `din`  in  1  serial data bit.
- `din_valid`  in  1  `din` is sampled only when this is 1.
- `cfg_load`  in  1  one-cycle strobe; captures `cfg_pattern`, `cfg_len`, `cfg_overlap`.
- `cfg_pattern`  in  MAX_LEN  pattern; bit [len-1] is the first bit received, bit [0] the last.
- `cfg_len`  in  LEN_W  pattern length.
- `cfg_overlap`  in  1  1 = overlapping matches allowed, 0 = non-overlapping.
- `clr_count`  in  1  synchronous clear of `match_count`.
- `y`  out  1  registered one-cycle match pulse.
- `match_count`  out  CNT_W  number of matches; saturates at all-ones.
- `cfg_err`  out  1  active length is 0 or greater than MAX_LEN.

## Operation
- **Active configuration registers:**
  - `pat_r` (MAX_LEN bits), `len_r`, `ovl_r`.
  - Reset values: RST_PAT, RST_LEN, RST_OVL.
- **History:**
  - `hist` is a MAX_LEN-bit shift register: on each valid bit, `hist <= {hist[MAX_LEN-2:0], din}`.
  - `fill` counts valid bits received since the last reset, config load or non-overlap match. It saturates at MAX_LEN.
- **Match condition**, evaluated on the post-shift history of a valid bit:
  - `fill_next ≥ len_r`, and
  - `hist_next[len_r-1:0] == pat_r[len_r-1:0]`, and
  - `cfg_err == 0`.
- **On a match:**
  - `y` is 1 for exactly one cycle.
  - `match_count` increments, saturating at 2^CNT_W−1.
  - If `ovl_r = 0`, `fill` is forced to 0, so the bits of the match cannot start a new match.
  - If `ovl_r = 1`, `fill` continues counting (saturating).
- **`cfg_load`:**
  - Captures the new configuration.
  - Clears `fill`, `hist` and `y`.
  - `match_count` is unchanged.
  - If `din_valid` is also 1 in the same cycle, `cfg_load` has priority and that `din` is discarded.
- **`cfg_err`:**
  - Combinational from `len_r`: 1 when `len_r == 0` or `len_r > MAX_LEN`.
  - While it is 1, no matches occur, but bits still shift into the history.
- **`din_valid = 0`:** `hist`, `fill` and `match_count` hold; `y` returns to 0.
- **`clr_count` with a match in the same cycle:** the clear wins; `match_count = 0` and that match is not counted. `y` still pulses.
- **State machine:** two implicit phases.
  - FILL: `fill < len_r`; matches are impossible.
  - ARMED: `fill ≥ len_r`.
  - A non-overlap match or `cfg_load` returns the block to FILL.
  - Reset enters FILL.

## Timing
- **Reset values:**
  - `y = 0`, `match_count = 0`, `hist = 0`, `fill = 0`.
  - Configuration = RST_* values.
  - `cfg_err` reflects RST_LEN.
  - Values take effect asynchronously on assertion of `reset`.
- **Reset deassertion:** the first rising edge after `reset` falls can sample `din`.
- **Latency:**
  - A bit sampled at edge k that completes a pattern drives `y = 1` from edge k until edge k+1.
  - `match_count` shows the new value after edge k.
  - There is no combinational path from `din` to `y`.
- **Back-to-back matches** (overlap mode, e.g. a pattern of all ones) give `y` high on consecutive cycles.
- **New configuration** is used for the first valid bit after the `cfg_load` edge.
- **Reset asserted mid-pattern:** a partial match is lost; there is no `y` pulse.

## Test plan
1. **Overlap default.** After reset, stream valid bits 1,0,1,1,0,1,1,0,1,1 → `y` high after bits 4, 7 and 10; `match_count = 3`.
2. **Non-overlap.** `cfg_load` with pattern 0b1011, len 4, overlap 0; stream the same 10 bits → `y` after bits 4 and 10 only; `match_count` goes from 3 to 5.
3. **Full-length pattern with gaps.** `cfg_load` with pattern 8'b1100_1010, len 8, overlap 1; send 1,1,0,0,1,0,1,0 with `din_valid` dropped for 2 cycles between bits 3 and 4 → a single `y` pulse the cycle after the 8th valid bit; no pulse during the gaps.
4. **Saturation and clear.** CNT_W = 2, pattern "1", len 1, overlap 1; send 5 ones → `y` on 5 consecutive cycles; `match_count` sequence 1,2,3,3,3. Then `clr_count` together with a sixth matching bit → `match_count = 0`, `y = 1`.
5. **Invalid length.** `cfg_load` with len 0 → `cfg_err = 1`, and no `y` for any stream. Then `cfg_load` with len 4 → `cfg_err = 0`.
6. **Priority and reset.**
   - `cfg_load` in the same cycle as `din_valid`: the bit is ignored.
   - Async `reset` asserted after bits 1,0,1 of "1011", then bit 1 sent after release → no `y`; outputs equal their reset values immediately on assertion, without waiting for an edge.

Source files
------------

// File: rtl/seq_detect_param.sv
// Serial bit-pattern detector with a runtime-programmable pattern/length,
// overlap mode, input qualification and a saturating match counter.
module seq_detect_param #(
  parameter int                 MAX_LEN = 8,
  parameter int                 CNT_W   = 8,
  parameter logic [MAX_LEN-1:0] RST_PAT = MAX_LEN'(8'b0000_1011),
  parameter int                 RST_LEN = 4,
  parameter logic               RST_OVL = 1'b1,
  parameter int                 LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               din,
  input  logic               din_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               clr_count,
  output logic               y,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err
);

  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               y_q, y_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [MAX_LEN-1:0] hist_nx;
  logic [LEN_W-1:0]   fill_nx;
  logic [MAX_LEN-1:0] len_msk;
  logic               match;

  // Low `len` bits set; lengths beyond MAX_LEN select the whole history.
  function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] len);
    logic [MAX_LEN-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (i < int'(len)) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [LEN_W-1:0] fill_sat_inc(input logic [LEN_W-1:0] v);
    return (v >= LEN_W'(MAX_LEN)) ? v : v + LEN_W'(1);
  endfunction

  assign cfg_err = (len_q == '0) || (len_q > LEN_W'(MAX_LEN));
  assign hist_nx = {hist_q[MAX_LEN-2:0], din};
  assign fill_nx = fill_sat_inc(fill_q);
  assign len_msk = len_mask(len_q);

  always_comb begin
    pat_d  = pat_q;
    len_d  = len_q;
    ovl_d  = ovl_q;
    hist_d = hist_q;
    fill_d = fill_q;
    y_d    = 1'b0;
    cnt_d  = cnt_q;
    match  = 1'b0;

    // A config load restarts the FILL phase and swallows any same-cycle bit.
    if (cfg_load) begin
      pat_d  = cfg_pattern;
      len_d  = cfg_len;
      ovl_d  = cfg_overlap;
      hist_d = '0;
      fill_d = '0;
    end else if (din_valid) begin
      hist_d = hist_nx;
      match  = !cfg_err && (fill_nx >= len_q) &&
               (((hist_nx ^ pat_q) & len_msk) == '0);
      fill_d = (match && !ovl_q) ? '0 : fill_nx;
      y_d    = match;
    end

    if (clr_count) begin
      cnt_d = '0;
    end else if (match) begin
      cnt_d = cnt_sat_inc(cnt_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_q  <= RST_PAT;
      len_q  <= LEN_W'(RST_LEN);
      ovl_q  <= RST_OVL;
      hist_q <= '0;
      fill_q <= '0;
      y_q    <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pat_q  <= pat_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      y_q    <= y_d;
      cnt_q  <= cnt_d;
    end
  end

  assign y           = y_q;
  assign match_count = cnt_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: table vectors, hand-written corner sequences and
// a randomized phase checked against a queue-based reference model.
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       din, din_valid, cfg_load, cfg_overlap, clr_count;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       y, cfg_err;
  logic [7:0] match_count;
  logic       y2, cfg_err2;
  logic [1:0] match_count2;

  int checks = 0;
  int errors = 0;

  seq_detect_param #(.MAX_LEN(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .clr_count(clr_count),
    .y(y), .match_count(match_count), .cfg_err(cfg_err)
  );

  seq_detect_param #(.MAX_LEN(8), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .clr_count(clr_count),
    .y(y2), .match_count(match_count2), .cfg_err(cfg_err2)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: bits received since the last restart, newest at the back.
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl;
  bit         m_q[$];
  int         m_cnt8, m_cnt2;
  bit         m_y;

  function automatic void model_reset();
    m_pat = 8'b0000_1011; m_len = 4; m_ovl = 1'b1;
    m_q.delete(); m_cnt8 = 0; m_cnt2 = 0; m_y = 1'b0;
  endfunction

  function automatic bit model_err();
    return (m_len == 0) || (m_len > 8);
  endfunction

  function automatic void model_step(input bit d, v, l, input logic [7:0] p,
                                     input logic [3:0] ln, input bit o, c);
    bit hit;
    hit = 1'b0;
    if (l) begin
      m_pat = p; m_len = int'(ln); m_ovl = o; m_q.delete();
    end else if (v) begin
      m_q.push_back(d);
      if (m_q.size() > 8) void'(m_q.pop_front());
      if (!model_err() && m_q.size() >= m_len) begin
        hit = 1'b1;
        for (int i = 0; i < m_len; i++)
          if (m_q[m_q.size() - m_len + i] != m_pat[m_len - 1 - i]) hit = 1'b0;
      end
      if (hit && !m_ovl) m_q.delete();
    end
    m_y = hit;
    if (c) begin
      m_cnt8 = 0; m_cnt2 = 0;
    end else if (hit) begin
      if (m_cnt8 < 255) m_cnt8++;
      if (m_cnt2 < 3) m_cnt2++;
    end
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply(input logic d, v, l, input logic [7:0] p,
                       input logic [3:0] ln, input logic o, c);
    din = d; din_valid = v; cfg_load = l; cfg_pattern = p; cfg_len = ln;
    cfg_overlap = o; clr_count = c;
    @(posedge clk);
    model_step(d, v, l, p, ln, o, c);
    #1;
    din_valid = 1'b0; cfg_load = 1'b0; clr_count = 1'b0;
  endtask

  task automatic bitin(input logic d);
    apply(d, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    #1 reset = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct packed {
    logic       din, vld, ld;
    logic [7:0] pat;
    logic [3:0] len;
    logic       ovl, clr, ey;
    logic [7:0] ecnt;
  } vec_t;

  vec_t tbl[21];
  logic [9:0] stream;
  logic [7:0] t3_bits;

  initial begin
    reset = 1'b1; din = 1'b0; din_valid = 1'b0; cfg_load = 1'b0;
    cfg_pattern = 8'h00; cfg_len = 4'd0; cfg_overlap = 1'b0; clr_count = 1'b0;
    model_reset();

    stream = 10'b1011011011;  // sent MSB first: 1,0,1,1,0,1,1,0,1,1
    // Overlapping default "1011": hits after bits 4, 7, 10.
    for (int i = 0; i < 10; i++) begin
      tbl[i] = '{din: stream[9-i], vld: 1'b1, ld: 1'b0, pat: 8'h00, len: 4'd0,
                 ovl: 1'b0, clr: 1'b0, ey: (i == 3 || i == 6 || i == 9),
                 ecnt: (i < 3) ? 8'd0 : (i < 6) ? 8'd1 : (i < 9) ? 8'd2 : 8'd3};
    end
    tbl[10] = '{din: 1'b0, vld: 1'b0, ld: 1'b1, pat: 8'h0B, len: 4'd4,
                ovl: 1'b0, clr: 1'b0, ey: 1'b0, ecnt: 8'd3};
    // Non-overlapping: hits after bits 4 and 10 only.
    for (int i = 0; i < 10; i++) begin
      tbl[11+i] = '{din: stream[9-i], vld: 1'b1, ld: 1'b0, pat: 8'h00, len: 4'd0,
                    ovl: 1'b0, clr: 1'b0, ey: (i == 3 || i == 9),
                    ecnt: (i < 3) ? 8'd3 : (i < 9) ? 8'd4 : 8'd5};
    end

    #3;
    chk("reset_y", {7'd0, y}, 8'd0);
    chk("reset_cnt", match_count, 8'd0);
    chk("reset_cfg_err", {7'd0, cfg_err}, 8'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 21; i++) begin
      apply(tbl[i].din, tbl[i].vld, tbl[i].ld, tbl[i].pat, tbl[i].len, tbl[i].ovl, tbl[i].clr);
      chk($sformatf("tbl%0d_y", i), {7'd0, y}, {7'd0, tbl[i].ey});
      chk($sformatf("tbl%0d_cnt", i), match_count, tbl[i].ecnt);
    end

    // Full-length pattern with din_valid gaps.
    apply(1'b0, 1'b0, 1'b1, 8'b1100_1010, 4'd8, 1'b1, 1'b0);
    t3_bits = 8'b1100_1010;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        for (int g = 0; g < 2; g++) begin
          apply(1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
          chk("t3_gap_y", {7'd0, y}, 8'd0);
        end
      end
      bitin(t3_bits[7-i]);
      chk($sformatf("t3_bit%0d_y", i), {7'd0, y}, {7'd0, (i == 7)});
    end
    chk("t3_cnt", match_count, 8'd6);

    // Saturation on the 2-bit counter, then clear racing a match.
    do_reset();
    apply(1'b0, 1'b0, 1'b1, 8'h01, 4'd1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      bitin(1'b1);
      chk($sformatf("t4_y%0d", i), {7'd0, y2}, 8'd1);
      chk($sformatf("t4_cnt2_%0d", i), {6'd0, match_count2}, (i < 3) ? 8'(i + 1) : 8'd3);
    end
    chk("t4_cnt8", match_count, 8'd5);
    apply(1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1);
    chk("t4_clr_y", {7'd0, y}, 8'd1);
    chk("t4_clr_cnt2", {6'd0, match_count2}, 8'd0);
    chk("t4_clr_cnt8", match_count, 8'd0);

    // Invalid lengths block matches but not shifting.
    apply(1'b0, 1'b0, 1'b1, 8'h01, 4'd0, 1'b1, 1'b0);
    chk("t5_err_len0", {7'd0, cfg_err}, 8'd1);
    for (int i = 0; i < 10; i++) begin
      bitin(1'($urandom_range(0, 1)));
      chk("t5_no_y", {7'd0, y}, 8'd0);
    end
    apply(1'b0, 1'b0, 1'b1, 8'hFF, 4'd9, 1'b1, 1'b0);
    chk("t5_err_len9", {7'd0, cfg_err}, 8'd1);
    for (int i = 0; i < 10; i++) begin
      bitin(1'b1);
      chk("t5_len9_no_y", {7'd0, y}, 8'd0);
    end
    apply(1'b0, 1'b0, 1'b1, 8'h0B, 4'd4, 1'b1, 1'b0);
    chk("t5_err_len4", {7'd0, cfg_err}, 8'd0);
    chk("t5_cnt", match_count, 8'd0);

    // cfg_load wins over a same-cycle valid bit.
    apply(1'b1, 1'b1, 1'b1, 8'h0B, 4'd4, 1'b1, 1'b0);
    bitin(1'b0); chk("t6_ld_y0", {7'd0, y}, 8'd0);
    bitin(1'b1); chk("t6_ld_y1", {7'd0, y}, 8'd0);
    bitin(1'b1); chk("t6_ld_y2", {7'd0, y}, 8'd0);
    bitin(1'b1); bitin(1'b0); bitin(1'b1); bitin(1'b1);
    chk("t6_match_y", {7'd0, y}, 8'd1);
    chk("t6_match_cnt", match_count, 8'd1);

    // Asynchronous reset clears outputs without a clock edge.
    reset = 1'b1;
    model_reset();
    #2;
    chk("t6_async_y", {7'd0, y}, 8'd0);
    chk("t6_async_cnt", match_count, 8'd0);
    @(negedge clk);
    reset = 1'b0;
    bitin(1'b1); bitin(1'b0); bitin(1'b1);
    reset = 1'b1;
    model_reset();
    #2;
    @(negedge clk);
    reset = 1'b0;
    bitin(1'b1);
    chk("t6_partial_lost_y", {7'd0, y}, 8'd0);
    chk("t6_partial_lost_cnt", match_count, 8'd0);

    // Randomized phase against the reference model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic       l, v, c, o;
      logic [7:0] p;
      logic [3:0] ln;
      l  = ($urandom_range(0, 99) < 4);
      v  = ($urandom_range(0, 99) < 75);
      c  = ($urandom_range(0, 99) < 2);
      o  = 1'($urandom_range(0, 1));
      p  = 8'($urandom);
      ln = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 4));
      apply(1'($urandom_range(0, 1)), v, l, p, ln, o, c);
      chk("rnd_y", {7'd0, y}, {7'd0, m_y});
      chk("rnd_cnt8", match_count, 8'(m_cnt8));
      chk("rnd_cnt2", {6'd0, match_count2}, 8'(m_cnt2));
      chk("rnd_cfg_err", {7'd0, cfg_err}, {7'd0, model_err()});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
